ddr2_ocd_zq_sequencer: RTL and testbench
========================================

Name: ddr2_ocd_zq_sequencer

Overview:
Initiator for the DDR2 OCD/ZQ calibration sequence. After a start handshake it drives the CA bus with EMRS1(OCD enter), a tOCD wait, EMRS1(OCD exit/default), a tMRD wait, an optional logical ZQ calibration command and a tZQinit wait. It then pulses done. It sits in the init path after the controller's MRS/EMRS programming, and its pad outputs feed the CA mux and the OCD/ZQ checker.

Parameters:
- EMRS1_OCD_ENTER_VAL, 13'h380: A[12:0] for EMRS1 OCD enter (A9:A7 = 111).
- EMRS1_OCD_EXIT_VAL, 13'h000: A[12:0] for EMRS1 OCD exit/default.
- ZQCAL_CMD_A_VAL, 13'h400: A[12:0] for the logical ZQ command.
- ZQCAL_CMD_BA_VAL, 2'b00: BA for the logical ZQ command.
- TMRD_CYCLES, 2: NOP cycles after OCD exit before the next command.
- TOCD_CYCLES, 4: NOP cycles between OCD enter and OCD exit.
- TZQINIT_CYCLES, 8: NOP cycles after the ZQ command before done.
- ZQ_EN, 1: 1 = issue the ZQ command; 0 = skip ZQ and its wait.

Ports:
- clk, input, 1: controller clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: request to run the sequence; sampled in IDLE only.
- cke_pad, input, 1: CKE as driven by the init controller; start is accepted only when this is 1.
- busy, output, 1: high from the cycle the enter command is driven through the last wait NOP.
- done, output, 1: one-cycle pulse after the final wait.
- csbar_pad, output, 1: chip select, active-low.
- rasbar_pad, output, 1: RAS, active-low.
- casbar_pad, output, 1: CAS, active-low.
- webar_pad, output, 1: WE, active-low.
- ba_pad, output, 2: bank address.
- a_pad, output, 13: address.

Behaviour:
- All outputs are registered.
- Reset and idle values: NOP (csbar=0, rasbar=1, casbar=1, webar=1), ba_pad=0, a_pad=0, busy=0, done=0.
- LM encoding: cs/ras/cas/we all 0, ba=2'b01, a=the configured value.
- ZQ encoding: cs=0, ras=1, cas=1, we=0, ba=ZQCAL_CMD_BA_VAL, a=ZQCAL_CMD_A_VAL.
- All non-command cycles drive NOP with ba=0, a=0.
- FSM states: IDLE, OCD_ENTER, WAIT_OCD, OCD_EXIT, WAIT_MRD, ZQ_CMD, WAIT_ZQ, DONE.
- IDLE: if start && cke_pad at edge k, enter OCD_ENTER. The enter command is on the pads in cycle k+1 (latency 1). Otherwise stay in IDLE.
- Each command state lasts exactly one cycle.
- WAIT_OCD: drives exactly max(TOCD_CYCLES,1) NOP cycles, then OCD_EXIT.
- WAIT_MRD: drives max(TMRD_CYCLES,1) NOPs, then ZQ_CMD if ZQ_EN=1, else DONE.
- WAIT_ZQ: drives max(TZQINIT_CYCLES,1) NOPs, then DONE.
- DONE: done=1 and busy=0 for one cycle, NOP on the pads, then IDLE.
- Wait counter: 16-bit down-counter, loaded with N-1 on entry to a wait state; the state exits when the counter reaches 0. Parameters above 65535 are unsupported (elaboration $error).
- start while not in IDLE is ignored (no queuing). start in the DONE cycle is also ignored.
- cke_pad falling mid-sequence does not abort; the sequence completes.
- reset mid-operation: at the next edge the FSM returns to IDLE, pads go to NOP, busy=0, done=0. No partial command is repeated.
- Only one ZQ command and one OCD enter are issued per start.
- With defaults the sequence satisfies the checker: the exit follows the enter by ≥TOCD NOPs, and ZQ follows the exit.

Decomposition:
- Shared include ddr2_cmd_defs.vh holds:
  - the {csbar,rasbar,casbar,webar} encodings CMD_NOP, CMD_LM, CMD_ZQ;
  - BA_EMRS1 = 2'b01;
  - the FSM state localparams (3-bit).
- One natural sub-module: ddr2_wait_counter, a loadable 16-bit down-counter with a zero flag. Other init sequencers reuse it.

Test Plan:
- Defaults, start pulse at cycle 0 with cke_pad=1:
  - cycle 1: LM, ba=01, a=13'h380;
  - cycles 2-5: NOP;
  - cycle 6: LM, a=13'h000;
  - cycles 7-8: NOP;
  - cycle 9: ZQ, ba=00, a=13'h400;
  - cycles 10-17: NOP, busy=1 throughout cycles 1-17;
  - cycle 18: done=1, busy=0; checker silent.
- ZQ_EN=0: cycles 1-8 as above, no ZQ pattern ever, done at cycle 9.
- start with cke_pad=0, then start held high at cycle 5 with cke_pad=1: the first start is ignored; the enter command appears at cycle 6; holding start through the whole run yields exactly one sequence before the next IDLE.
- reset asserted in cycle 3 (WAIT_OCD): from cycle 4 pads are NOP with busy=0 and no exit command. A fresh start then produces a complete sequence with exactly one enter as seen by the checker.
- TOCD_CYCLES=0, TMRD_CYCLES=0, TZQINIT_CYCLES=0: each wait is 1 NOP; enter at 1, exit at 3, ZQ at 5, done at 7.
- Back-to-back: start asserted in the DONE cycle is ignored; start in the following IDLE cycle begins a new sequence one cycle later.

Source files
------------

// File: rtl/ddr2_ocd_zq_sequencer_pkg.sv
// ddr2_ocd_zq_sequencer_pkg: CA command encodings, FSM states and wait helper shared by init sequencers
package ddr2_ocd_zq_sequencer_pkg;
  localparam logic [3:0] CMD_NOP = 4'b0111;
  localparam logic [3:0] CMD_LM = 4'b0000;
  localparam logic [3:0] CMD_ZQ = 4'b0110;
  localparam logic [1:0] BA_EMRS1 = 2'b01;
  typedef enum logic [2:0] {
    IDLE, OCD_ENTER, WAIT_OCD, OCD_EXIT, WAIT_MRD, ZQ_CMD, WAIT_ZQ, DONE
  } state_t;
  function automatic logic [15:0] wait_load(input int n);
    return (n < 1) ? 16'd0 : 16'(n - 1);
  endfunction
endpackage

// File: rtl/ddr2_wait_counter.sv
// ddr2_wait_counter: loadable 16-bit down-counter with zero flag, holds at zero
module ddr2_wait_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic        zero
);
  logic [15:0] cnt;
  always_ff @(posedge clk)
    if (reset) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (cnt != 16'd0) cnt <= cnt - 16'd1;
  assign zero = (cnt == 16'd0);
endmodule

// File: rtl/ddr2_ocd_zq_sequencer.sv
// ddr2_ocd_zq_sequencer: drives EMRS1 OCD enter/exit and optional ZQ command with timed NOP waits
module ddr2_ocd_zq_sequencer
  import ddr2_ocd_zq_sequencer_pkg::*;
#(
  parameter logic [12:0] EMRS1_OCD_ENTER_VAL = 13'h380,
  parameter logic [12:0] EMRS1_OCD_EXIT_VAL = 13'h000,
  parameter logic [12:0] ZQCAL_CMD_A_VAL = 13'h400,
  parameter logic [1:0] ZQCAL_CMD_BA_VAL = 2'b00,
  parameter int TMRD_CYCLES = 2,
  parameter int TOCD_CYCLES = 4,
  parameter int TZQINIT_CYCLES = 8,
  parameter bit ZQ_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        cke_pad,
  output logic        busy,
  output logic        done,
  output logic        csbar_pad,
  output logic        rasbar_pad,
  output logic        casbar_pad,
  output logic        webar_pad,
  output logic [1:0]  ba_pad,
  output logic [12:0] a_pad
);
  if (TMRD_CYCLES > 65535 || TOCD_CYCLES > 65535 || TZQINIT_CYCLES > 65535) begin : g_range
    $error("wait cycle parameters above 65535 are unsupported");
  end
  state_t state, nxt;
  logic load, zero;
  logic [15:0] load_val;
  logic [3:0] cmd_n;
  logic [1:0] ba_n;
  logic [12:0] a_n;
  ddr2_wait_counter u_wait (.clk(clk), .reset(reset), .load(load), .load_val(load_val), .zero(zero));
  always_comb begin
    nxt = state;
    load = 1'b0;
    load_val = '0;
    case (state)
      IDLE:      nxt = (start && cke_pad) ? OCD_ENTER : IDLE;
      OCD_ENTER: begin nxt = WAIT_OCD; load = 1'b1; load_val = wait_load(TOCD_CYCLES); end
      WAIT_OCD:  nxt = zero ? OCD_EXIT : WAIT_OCD;
      OCD_EXIT:  begin nxt = WAIT_MRD; load = 1'b1; load_val = wait_load(TMRD_CYCLES); end
      WAIT_MRD:  nxt = zero ? (ZQ_EN ? ZQ_CMD : DONE) : WAIT_MRD;
      ZQ_CMD:    begin nxt = WAIT_ZQ; load = 1'b1; load_val = wait_load(TZQINIT_CYCLES); end
      WAIT_ZQ:   nxt = zero ? DONE : WAIT_ZQ;
      default:   nxt = IDLE;
    endcase
  end
  // Pads are registered from the next-state decode so a command appears the cycle its state is entered
  always_comb begin
    cmd_n = (nxt == OCD_ENTER || nxt == OCD_EXIT) ? CMD_LM : (nxt == ZQ_CMD) ? CMD_ZQ : CMD_NOP;
    ba_n = (cmd_n == CMD_LM) ? BA_EMRS1 : (nxt == ZQ_CMD) ? ZQCAL_CMD_BA_VAL : 2'b00;
    a_n = (nxt == OCD_ENTER) ? EMRS1_OCD_ENTER_VAL : (nxt == OCD_EXIT) ? EMRS1_OCD_EXIT_VAL :
          (nxt == ZQ_CMD) ? ZQCAL_CMD_A_VAL : 13'h0;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      {csbar_pad, rasbar_pad, casbar_pad, webar_pad} <= CMD_NOP;
      ba_pad <= '0;
      a_pad <= '0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= nxt;
      {csbar_pad, rasbar_pad, casbar_pad, webar_pad} <= cmd_n;
      ba_pad <= ba_n;
      a_pad <= a_n;
      busy <= (nxt != IDLE) && (nxt != DONE);
      done <= (nxt == DONE);
    end
endmodule

// File: tb/tb_ddr2_ocd_zq_sequencer.sv
// tb_ddr2_ocd_zq_sequencer: vector table for the default build plus directed runs for ZQ-off and zero-wait builds
module tb_ddr2_ocd_zq_sequencer;
  localparam logic [3:0] NOP = 4'b0111, LM = 4'b0000, ZQ = 4'b0110;
  typedef struct {
    logic r, s, c;
    logic [20:0] exp;
  } vec_t;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, start_z = 1'b0, start_0 = 1'b0, cke = 1'b1;
  logic [20:0] out_d, out_z, out_0;
  int compared = 0, mismatched = 0;
  vec_t vecs[$];
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic bs, dn, cs, ras, cas, we;
    logic [1:0] ba;
    logic [12:0] a;
    if (g == 0) begin : g_def
      ddr2_ocd_zq_sequencer dut (.clk(clk), .reset(reset), .start(start), .cke_pad(cke), .busy(bs), .done(dn),
        .csbar_pad(cs), .rasbar_pad(ras), .casbar_pad(cas), .webar_pad(we), .ba_pad(ba), .a_pad(a));
    end else if (g == 1) begin : g_nozq
      ddr2_ocd_zq_sequencer #(.ZQ_EN(1'b0)) dut (.clk(clk), .reset(reset), .start(start_z), .cke_pad(cke),
        .busy(bs), .done(dn), .csbar_pad(cs), .rasbar_pad(ras), .casbar_pad(cas), .webar_pad(we), .ba_pad(ba), .a_pad(a));
    end else begin : g_zero
      ddr2_ocd_zq_sequencer #(.TOCD_CYCLES(0), .TMRD_CYCLES(0), .TZQINIT_CYCLES(0)) dut (.clk(clk), .reset(reset),
        .start(start_0), .cke_pad(cke), .busy(bs), .done(dn), .csbar_pad(cs), .rasbar_pad(ras), .casbar_pad(cas),
        .webar_pad(we), .ba_pad(ba), .a_pad(a));
    end
  end
  assign out_d = {g_dut[0].cs, g_dut[0].ras, g_dut[0].cas, g_dut[0].we, g_dut[0].ba, g_dut[0].a, g_dut[0].bs, g_dut[0].dn};
  assign out_z = {g_dut[1].cs, g_dut[1].ras, g_dut[1].cas, g_dut[1].we, g_dut[1].ba, g_dut[1].a, g_dut[1].bs, g_dut[1].dn};
  assign out_0 = {g_dut[2].cs, g_dut[2].ras, g_dut[2].cas, g_dut[2].we, g_dut[2].ba, g_dut[2].a, g_dut[2].bs, g_dut[2].dn};

  function automatic logic [20:0] pk(input logic [3:0] cmd, input logic [1:0] ba, input logic [12:0] a,
                                     input logic bs, input logic dn);
    return {cmd, ba, a, bs, dn};
  endfunction

  task automatic chk(input string name, input logic [20:0] act, input logic [20:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got cmd=%b ba=%b a=%h busy=%b done=%b, want cmd=%b ba=%b a=%h busy=%b done=%b", name,
               act[20:17], act[16:15], act[14:2], act[1], act[0], exp[20:17], exp[16:15], exp[14:2], exp[1], exp[0]);
    end
  endtask

  task automatic add(input logic r, input logic s, input logic c, input logic [20:0] exp);
    vec_t v;
    v.r = r; v.s = s; v.c = c; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Cycles 1..17 of a default run (enter through last ZQ wait NOP), start held at s
  task automatic add_run(input logic s);
    add(0, s, 1, pk(LM, 2'b01, 13'h380, 1, 0));
    for (int i = 0; i < 4; i++) add(0, s, 1, pk(NOP, 0, 0, 1, 0));
    add(0, s, 1, pk(LM, 2'b01, 13'h000, 1, 0));
    for (int i = 0; i < 2; i++) add(0, s, 1, pk(NOP, 0, 0, 1, 0));
    add(0, s, 1, pk(ZQ, 2'b00, 13'h400, 1, 0));
    for (int i = 0; i < 8; i++) add(0, s, 1, pk(NOP, 0, 0, 1, 0));
  endtask

  initial begin
    logic [20:0] exp_z[12];
    logic [20:0] exp_0[9];
    add(0, 1, 1, pk(NOP, 0, 0, 0, 0));
    add_run(0);
    add(0, 1, 1, pk(NOP, 0, 0, 0, 1));
    add(0, 1, 1, pk(NOP, 0, 0, 0, 0));
    add(0, 0, 1, pk(LM, 2'b01, 13'h380, 1, 0));
    add(0, 0, 1, pk(NOP, 0, 0, 1, 0));
    add(1, 0, 1, pk(NOP, 0, 0, 1, 0));
    add(0, 0, 1, pk(NOP, 0, 0, 0, 0));
    add(0, 1, 0, pk(NOP, 0, 0, 0, 0));
    add(0, 0, 1, pk(NOP, 0, 0, 0, 0));
    add(0, 1, 1, pk(NOP, 0, 0, 0, 0));
    add_run(1);
    add(0, 1, 1, pk(NOP, 0, 0, 0, 1));
    add(0, 1, 1, pk(NOP, 0, 0, 0, 0));
    add(0, 0, 1, pk(LM, 2'b01, 13'h380, 1, 0));
    add(1, 0, 1, pk(NOP, 0, 0, 1, 0));
    add(0, 0, 1, pk(NOP, 0, 0, 0, 0));

    exp_z[0] = pk(NOP, 0, 0, 0, 0);
    exp_z[1] = pk(LM, 2'b01, 13'h380, 1, 0);
    for (int i = 2; i <= 5; i++) exp_z[i] = pk(NOP, 0, 0, 1, 0);
    exp_z[6] = pk(LM, 2'b01, 13'h000, 1, 0);
    exp_z[7] = pk(NOP, 0, 0, 1, 0);
    exp_z[8] = pk(NOP, 0, 0, 1, 0);
    exp_z[9] = pk(NOP, 0, 0, 0, 1);
    exp_z[10] = pk(NOP, 0, 0, 0, 0);
    exp_z[11] = pk(NOP, 0, 0, 0, 0);

    exp_0[0] = pk(NOP, 0, 0, 0, 0);
    exp_0[1] = pk(LM, 2'b01, 13'h380, 1, 0);
    exp_0[2] = pk(NOP, 0, 0, 1, 0);
    exp_0[3] = pk(LM, 2'b01, 13'h000, 1, 0);
    exp_0[4] = pk(NOP, 0, 0, 1, 0);
    exp_0[5] = pk(ZQ, 2'b00, 13'h400, 1, 0);
    exp_0[6] = pk(NOP, 0, 0, 1, 0);
    exp_0[7] = pk(NOP, 0, 0, 0, 1);
    exp_0[8] = pk(NOP, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      reset = vecs[i].r;
      start = vecs[i].s;
      cke = vecs[i].c;
      chk($sformatf("vec%0d", i), out_d, vecs[i].exp);
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    start = 1'b0;
    cke = 1'b1;
    for (int i = 0; i < 12; i++) begin
      start_z = (i == 0);
      chk($sformatf("nozq_c%0d", i), out_z, exp_z[i]);
      @(posedge clk);
      #1;
    end
    start_z = 1'b0;
    for (int i = 0; i < 9; i++) begin
      start_0 = (i == 0);
      chk($sformatf("zero_c%0d", i), out_0, exp_0[i]);
      @(posedge clk);
      #1;
    end
    start_0 = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
